array_7_fifo_ctrl: RTL and testbench

//  Sync FIFO controller that sits directly in front of the 8x80 1R1W array macro (array_7_ext).
//  - Drives the macro's W0/R0 ports; presents enq/deq valid-ready handshakes to the pipeline.
//  - deq_bits comes straight from macro R0_data. The macro holds its registered read address while R0_en=0,
//    so the head entry stays stable without an extra 80-bit output register.

---
 rtl/array_7_fifo_ctrl.sv | 133 +++++++++++++
 tb/tb_array_7_fifo_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_7_fifo_ctrl.sv
// Sync FIFO controller driving the 8x80 1R1W array macro (array_7_ext) W0/R0 ports.
// Latency: enq->deq_valid 2 cycles (1 cycle with ARRAY_7_FIFO_BYPASS_EN defined); 1 enq + 1 deq per cycle sustained.
// Backpressure: enq_ready = not full from registered state only; head held on the macro output while deq_ready=0.
module array_7_fifo_ctrl #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 80,
   parameter int AW    = 3
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             enq_valid,
   output logic             enq_ready,
   input  logic [WIDTH-1:0] enq_bits,
   output logic             deq_valid,
   input  logic             deq_ready,
   output logic [WIDTH-1:0] deq_bits,
   output logic [AW:0]      count,
   output logic [AW-1:0]    sram_w_addr,
   output logic             sram_w_en,
   output logic [WIDTH-1:0] sram_w_data,
   output logic [AW-1:0]    sram_r_addr,
   output logic             sram_r_en,
   input  logic [WIDTH-1:0] sram_r_data
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   logic [AW:0] wptr_q, wptr_d;   // next slot to write
   logic [AW:0] rptr_q, rptr_d;   // next slot to read from the macro
   logic [AW:0] hptr_q, hptr_d;   // oldest entry not yet dequeued
   logic        out_valid_q, out_valid_d;

   logic [AW:0]   pend;
   logic          enq_fire;
   logic          deq_fire;
   logic          rd_slot_free;
   logic          rd_norm;
   logic          rd_byp;
   logic          rd_fire;
   logic [AW-1:0] rd_idx;

   // Occupancy counts the presented entry too; pend counts written entries not yet read.
   assign count     = wptr_q - hptr_q;
   assign pend      = wptr_q - rptr_q;

   assign enq_ready = (count != FULL_CNT);
   assign enq_fire  = enq_valid & enq_ready;

   assign deq_valid = out_valid_q;
   assign deq_fire  = out_valid_q & deq_ready;

   // The macro keeps its registered read address while R0_en is low, so its
   // output doubles as the head register.
   assign deq_bits  = sram_r_data;

   // A new read may be issued when the output stage is empty or being drained.
   assign rd_slot_free = ~out_valid_q | deq_fire;
   assign rd_norm      = (pend != '0) & rd_slot_free;

`ifdef ARRAY_7_FIFO_BYPASS_EN
   // Nothing pending: read the slot being written this cycle; the macro
   // shows the new data after the edge.
   assign rd_byp = (pend == '0) & rd_slot_free & enq_fire;
`else
   assign rd_byp = 1'b0;
`endif

   assign rd_fire = rd_norm | rd_byp;
   assign rd_idx  = rd_byp ? wptr_q[AW-1:0] : rptr_q[AW-1:0];

   // Next-state for pointers and the output-valid flag.
   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      hptr_d      = hptr_q;
      out_valid_d = rd_fire | (out_valid_q & ~deq_fire);
      if (enq_fire) begin
         wptr_d = wptr_q + PTR_ONE;
      end
      if (rd_fire) begin
         rptr_d = rptr_q + PTR_ONE;
      end
      if (deq_fire) begin
         hptr_d = hptr_q + PTR_ONE;
      end
   end

   // Macro port drive; address and data forced to zero while the enable is low.
   always_comb begin
      sram_w_en   = 1'b0;
      sram_w_addr = '0;
      sram_w_data = '0;
      sram_r_en   = 1'b0;
      sram_r_addr = '0;
      if (enq_fire) begin
         sram_w_en   = 1'b1;
         sram_w_addr = wptr_q[AW-1:0];
         sram_w_data = enq_bits;
      end
      if (rd_fire) begin
         sram_r_en   = 1'b1;
         sram_r_addr = rd_idx;
      end
   end

   // State registers; reset drops all entries but leaves the array untouched.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         hptr_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         hptr_q      <= hptr_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Occupancy can never exceed the array depth.
   assert property (@(posedge clock) disable iff (!reset_n) count <= FULL_CNT);

   // The presented head slot must never be overwritten.
   assert property (@(posedge clock) disable iff (!reset_n)
      !(sram_w_en && out_valid_q && (sram_w_addr == hptr_q[AW-1:0])));

   // Reads never run ahead of writes.
   assert property (@(posedge clock) disable iff (!reset_n) pend <= count);

endmodule

// File: tb/tb_array_7_fifo_ctrl.sv
// Testbench for array_7_fifo_ctrl with a behavioural 8x80 array macro.
// Reference model: queue of entries with enqueue time; each entry is presented at
// max(enq_time + latency, previous dequeue + 1).
module tb_array_7_fifo_ctrl;

   localparam int DEPTH = 8;
   localparam int WIDTH = 80;
   localparam int AW    = 3;
`ifdef ARRAY_7_FIFO_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic             clock = 1'b0;
   logic             reset_n;
   logic             enq_valid;
   logic             enq_ready;
   logic [WIDTH-1:0] enq_bits;
   logic             deq_valid;
   logic             deq_ready;
   logic [WIDTH-1:0] deq_bits;
   logic [AW:0]      count;
   logic [AW-1:0]    sram_w_addr;
   logic             sram_w_en;
   logic [WIDTH-1:0] sram_w_data;
   logic [AW-1:0]    sram_r_addr;
   logic             sram_r_en;
   logic [WIDTH-1:0] sram_r_data;

   array_7_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .enq_valid   (enq_valid),
      .enq_ready   (enq_ready),
      .enq_bits    (enq_bits),
      .deq_valid   (deq_valid),
      .deq_ready   (deq_ready),
      .deq_bits    (deq_bits),
      .count       (count),
      .sram_w_addr (sram_w_addr),
      .sram_w_en   (sram_w_en),
      .sram_w_data (sram_w_data),
      .sram_r_addr (sram_r_addr),
      .sram_r_en   (sram_r_en),
      .sram_r_data (sram_r_data)
   );

   always #5 clock = ~clock;

   // Array macro: write-before-read, registered read address held while R0_en=0.
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    mem_raddr_q = '0;
   always @(posedge clock) begin
      if (sram_w_en) mem[sram_w_addr] <= sram_w_data;
      if (sram_r_en) mem_raddr_q <= sram_r_addr;
   end
   assign sram_r_data = mem[mem_raddr_q];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model state.
   typedef struct {
      logic [WIDTH-1:0] d;
      int               t;
   } ent_t;
   ent_t q[$];
   int   cyc       = 0;
   int   last_deq  = -100;
   int   wr_total  = 0;
   int   deq_total = 0;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic model_reset();
      q.delete();
      last_deq  = -100;
      wr_total  = 0;
      deq_total = 0;
   endtask

   // One clock cycle: check at negedge, advance model at posedge, return at posedge+1.
   task automatic step();
      bit               exp_er, exp_dv, exp_re, enq_f, deq_f, have, blocked;
      int               e, blk, t;
      logic [WIDTH-1:0] cur_bits;
      @(negedge clock);
      cur_bits = enq_bits;
      exp_er   = (q.size() != DEPTH);
      exp_dv   = (q.size() > 0) && (cyc >= imax(q[0].t + LAT, last_deq + 1));
      enq_f    = enq_valid && exp_er;
      deq_f    = exp_dv && deq_ready;

      chk("count", count, q.size());
      chk("enq_ready", enq_ready, exp_er);
      chk("deq_valid", deq_valid, exp_dv);
      if (exp_dv) chk("deq_bits", deq_bits, q[0].d);

      chk("w_en", sram_w_en, enq_f);
      if (enq_f) begin
         chk("w_addr", sram_w_addr, wr_total % DEPTH);
         chk("w_data", sram_w_data, cur_bits);
      end else begin
         chk("w_addr_idle", sram_w_addr, 0);
         chk("w_data_idle", sram_w_data, 0);
      end

      // Next entry to be read and what holds it back.
      have = 0; e = 0; blk = last_deq; blocked = 0;
      if (exp_dv) begin
         blocked = !deq_f;
         blk     = cyc;
         if (q.size() > 1) begin have = 1; e = q[1].t; end
         else if (enq_f) begin have = 1; e = cyc; end
      end else begin
         if (q.size() > 0) begin have = 1; e = q[0].t; end
         else if (enq_f) begin have = 1; e = cyc; end
      end
      t      = imax(e + LAT, blk + 1);
      exp_re = have && !blocked && (t == cyc + 1);
      chk("r_en", sram_r_en, exp_re);
      if (exp_re) chk("r_addr", sram_r_addr, (deq_total + (exp_dv ? 1 : 0)) % DEPTH);
      else        chk("r_addr_idle", sram_r_addr, 0);

      @(posedge clock);
      if (deq_f) begin
         void'(q.pop_front());
         last_deq = cyc;
         deq_total++;
      end
      if (enq_f) begin
         q.push_back('{d: cur_bits, t: cyc});
         wr_total++;
      end
      cyc++;
      #1;
   endtask

   task automatic drain();
      enq_valid = 1'b0;
      deq_ready = 1'b1;
      for (int i = 0; i < 40 && q.size() > 0; i++) step();
      chk("drain_count", count, 0);
      chk("drain_valid", deq_valid, 0);
   endtask

   function automatic logic [WIDTH-1:0] rnd80();
      logic [95:0] r;
      r = {$urandom, $urandom, $urandom};
      return r[WIDTH-1:0];
   endfunction

   initial begin
      int lat;
      int target;
      reset_n   = 1'b0;
      enq_valid = 1'b0;
      enq_bits  = '0;
      deq_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_count", count, 0);
      chk("rst_deq_valid", deq_valid, 0);
      chk("rst_enq_ready", enq_ready, 1);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      // Latency from an empty FIFO.
      enq_valid = 1'b1;
      enq_bits  = 80'h1234;
      step();
      enq_valid = 1'b0;
      enq_bits  = rnd80();
      lat = 0;
      for (int k = 1; k <= 4; k++) begin
         if (deq_valid && lat == 0) lat = k;
         step();
      end
      chk("latency", lat, LAT);
      chk("lat_data", deq_bits, 80'h1234);
      drain();

      // Fill to full, hold a 9th request, then full + deq in the same cycle.
      deq_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         enq_valid = 1'b1;
         enq_bits  = WIDTH'(i);
         step();
      end
      chk("full_count", count, 8);
      chk("full_ready", enq_ready, 0);
      enq_bits = WIDTH'(8);
      repeat (3) step();
      chk("full_hold_count", count, 8);
      enq_bits  = WIDTH'(99);
      deq_ready = 1'b1;
      chk("fd_ready_a", enq_ready, 0);
      step();
      chk("fd_count_b", count, 7);
      chk("fd_ready_b", enq_ready, 1);
      deq_ready = 1'b0;
      step();
      chk("fd_count_c", count, 8);
      drain();

      // Streaming across two pointer wraps.
      for (int i = 0; i < 20; i++) begin
         enq_valid = 1'b1;
         deq_ready = 1'b1;
         enq_bits  = WIDTH'(i);
         step();
      end
      drain();

      // Random backpressure, 100 enqueues.
      target = wr_total + 100;
      for (int c = 0; c < 3000 && wr_total < target; c++) begin
         enq_valid = ($urandom_range(0, 3) != 0);
         deq_ready = ($urandom_range(0, 2) == 0);
         enq_bits  = rnd80();
         step();
      end
      drain();

      // Reset mid-stream with five entries held.
      deq_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         enq_valid = 1'b1;
         enq_bits  = rnd80();
         step();
      end
      enq_valid = 1'b0;
      chk("pre_rst_count", count, 5);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_count", count, 0);
      chk("mid_rst_deq_valid", deq_valid, 0);
      chk("mid_rst_enq_ready", enq_ready, 1);
      model_reset();
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      enq_valid = 1'b1;
      enq_bits  = 80'hA5;
      step();
      enq_valid = 1'b0;
      for (int k = 0; k < LAT - 1; k++) step();
      chk("post_rst_valid", deq_valid, 1);
      chk("post_rst_data", deq_bits, 80'hA5);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
